// File: rtl/sonuc_bcd_cevirici_pkg.sv
// rtl/sonuc_bcd_cevirici_pkg.sv - shared types and constants for the result-to-BCD converter (optional SIFIR_BASTIR_EN helper)
package hesap_pkg;

    localparam int KESIR_BIT      = 16;
    localparam int VERI_GENISLIGI = 32;
    localparam int BASAMAK        = 10;

    typedef enum logic [1:0] {
        BOS    = 2'd0,
        YUKLE  = 2'd1,
        KAYDIR = 2'd2,
        BITTI  = 2'd3
    } durum_t;

    typedef logic [3:0] bcd_nibble_t;

`ifdef SIFIR_BASTIR_EN
    // Walk from the top digit down; a digit is blanked while everything above it is zero.
    // Digit 0 is always shown so a zero result still displays "0".
    function automatic logic [BASAMAK-1:0] bos_maske_hesapla(input logic [4*BASAMAK-1:0] bcd);
        logic [BASAMAK-1:0] maske;
        logic               hep_sifir;
        maske     = '0;
        hep_sifir = 1'b1;
        for (int k = BASAMAK - 1; k >= 1; k--) begin
            hep_sifir = hep_sifir & (bcd[4*k +: 4] == 4'd0);
            maske[k]  = hep_sifir;
        end
        return maske;
    endfunction
`endif

endpackage

// File: rtl/sonuc_bcd_cevirici_if.sv
// rtl/sonuc_bcd_cevirici_if.sv - arithmetic-result input and BCD output bundle (bos_mask only with SIFIR_BASTIR_EN)
interface sonuc_bcd_cevirici_if;
    import hesap_pkg::*;

    logic [63:0]          sonuc;
    logic                 hazir;
    logic                 gecerli;
    logic [4*BASAMAK-1:0] basamak;
    logic                 isaret;
    logic                 cikis_gecerli;
    logic                 mesgul;
`ifdef SIFIR_BASTIR_EN
    logic [BASAMAK-1:0]   bos_mask;

    modport master (output sonuc, hazir, gecerli,
                    input  basamak, isaret, cikis_gecerli, mesgul, bos_mask);
    modport slave  (input  sonuc, hazir, gecerli,
                    output basamak, isaret, cikis_gecerli, mesgul, bos_mask);
`else
    modport master (output sonuc, hazir, gecerli,
                    input  basamak, isaret, cikis_gecerli, mesgul);
    modport slave  (input  sonuc, hazir, gecerli,
                    output basamak, isaret, cikis_gecerli, mesgul);
`endif

endinterface

// File: rtl/sonuc_bcd_cevirici_duzelt.sv
// rtl/sonuc_bcd_cevirici_duzelt.sv - single BCD nibble add-3 correction for double-dabble
module bcd_basamak_duzelt
    import hesap_pkg::*;
(
    input  bcd_nibble_t giris,
    output bcd_nibble_t cikis
);

    // A nibble of 5..9 would overflow past 9 after the shift, so pre-bias it by 3.
    always_comb begin
        cikis = giris;
        if (giris >= 4'd5) begin
            cikis = giris + 4'd3;
        end
    end

endmodule

// File: rtl/sonuc_bcd_cevirici.sv
// rtl/sonuc_bcd_cevirici.sv - sequential signed fixed-point integer to sign+BCD converter (optional SIFIR_BASTIR_EN)
module sonuc_bcd_cevirici
    import hesap_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    sonuc_bcd_cevirici_if.slave    bus
);

    localparam int BW = 4 * BASAMAK;
    localparam int VW = VERI_GENISLIGI;
    localparam int SW = $clog2(VERI_GENISLIGI + 1);

    durum_t        durum_q,      durum_d;
    logic [63:0]   son_sonuc_q,  son_sonuc_d;
    logic          yakalandi_q,  yakalandi_d;
    logic [VW-1:0] m_q,          m_d;
    logic [BW-1:0] bcd_q,        bcd_d;
    logic [SW-1:0] sayac_q,      sayac_d;
    logic          isaret_r_q,   isaret_r_d;
    logic [BW-1:0] basamak_q,    basamak_d;
    logic          isaret_q,     isaret_d;
    logic          cikis_q,      cikis_d;
`ifdef SIFIR_BASTIR_EN
    logic [BASAMAK-1:0] bos_mask_q, bos_mask_d;
`endif

    logic [VW-1:0]    x;
    logic [BW-1:0]    bcd_duz;
    logic [BW+VW-1:0] birlesik;
    logic [BW-1:0]    bcd_kay;
    logic [VW-1:0]    m_kay;
    logic             kabul;

    // Add-3 correction on every digit before the shift.
    for (genvar g = 0; g < BASAMAK; g++) begin : g_duzelt
        bcd_basamak_duzelt u_duzelt (
            .giris (bcd_q[4*g +: 4]),
            .cikis (bcd_duz[4*g +: 4])
        );
    end

    assign x        = bus.sonuc[KESIR_BIT + VW - 1 : KESIR_BIT];
    assign birlesik = {bcd_duz, m_q};
    assign bcd_kay  = birlesik[BW + VW - 2 -: BW];
    assign m_kay    = {m_q[VW-2:0], 1'b0};

    // Levels stay high upstream, so only a result different from the last one converted starts work.
    assign kabul = bus.hazir & bus.gecerli & (durum_q == BOS) &
                   (~yakalandi_q | (bus.sonuc != son_sonuc_q));

    // Next-state and datapath: load magnitude, shift VW times, publish on the last shift.
    always_comb begin
        durum_d     = durum_q;
        son_sonuc_d = son_sonuc_q;
        yakalandi_d = yakalandi_q;
        m_d         = m_q;
        bcd_d       = bcd_q;
        sayac_d     = sayac_q;
        isaret_r_d  = isaret_r_q;
        basamak_d   = basamak_q;
        isaret_d    = isaret_q;
        cikis_d     = 1'b0;
`ifdef SIFIR_BASTIR_EN
        bos_mask_d  = bos_mask_q;
`endif
        case (durum_q)
            BOS: begin
                if (kabul) begin
                    durum_d = YUKLE;
                end
            end
            YUKLE: begin
                son_sonuc_d = bus.sonuc;
                yakalandi_d = 1'b1;
                isaret_r_d  = x[VW-1];
                m_d         = x[VW-1] ? (~x + 1'b1) : x;
                bcd_d       = '0;
                sayac_d     = SW'(VW);
                durum_d     = KAYDIR;
            end
            KAYDIR: begin
                bcd_d   = bcd_kay;
                m_d     = m_kay;
                sayac_d = sayac_q - SW'(1);
                if (sayac_q == SW'(1)) begin
                    durum_d   = BITTI;
                    basamak_d = bcd_kay;
                    isaret_d  = isaret_r_q & (bcd_kay != '0);
                    cikis_d   = 1'b1;
`ifdef SIFIR_BASTIR_EN
                    bos_mask_d = bos_maske_hesapla(bcd_kay);
`endif
                end
            end
            BITTI: begin
                durum_d = BOS;
            end
            default: begin
                durum_d = BOS;
            end
        endcase
    end

    // State and output registers; reset aborts any conversion and forgets the last result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            durum_q     <= BOS;
            son_sonuc_q <= '0;
            yakalandi_q <= 1'b0;
            m_q         <= '0;
            bcd_q       <= '0;
            sayac_q     <= '0;
            isaret_r_q  <= 1'b0;
            basamak_q   <= '0;
            isaret_q    <= 1'b0;
            cikis_q     <= 1'b0;
`ifdef SIFIR_BASTIR_EN
            bos_mask_q  <= '0;
`endif
        end else begin
            durum_q     <= durum_d;
            son_sonuc_q <= son_sonuc_d;
            yakalandi_q <= yakalandi_d;
            m_q         <= m_d;
            bcd_q       <= bcd_d;
            sayac_q     <= sayac_d;
            isaret_r_q  <= isaret_r_d;
            basamak_q   <= basamak_d;
            isaret_q    <= isaret_d;
            cikis_q     <= cikis_d;
`ifdef SIFIR_BASTIR_EN
            bos_mask_q  <= bos_mask_d;
`endif
        end
    end

    assign bus.basamak       = basamak_q;
    assign bus.isaret        = isaret_q;
    assign bus.cikis_gecerli = cikis_q;
    assign bus.mesgul        = (durum_q != BOS);
`ifdef SIFIR_BASTIR_EN
    assign bus.bos_mask      = bos_mask_q;
`endif

endmodule

// File: tb/tb_sonuc_bcd_cevirici.sv
// tb/tb_sonuc_bcd_cevirici.sv - directed bench for sonuc_bcd_cevirici (mask checks with SIFIR_BASTIR_EN)
module tb_sonuc_bcd_cevirici;

    logic clk;
    logic rst_n;
    int   vec;
    int   miss;
    int   n;
    int   mcnt;

    sonuc_bcd_cevirici_if bus ();

    sonuc_bcd_cevirici dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_conv(input logic [63:0] s);
        @(negedge clk);
        bus.sonuc   = s;
        bus.hazir   = 1'b1;
        bus.gecerli = 1'b1;
    endtask

    task automatic wait_pulse(input string tag, input int exp_lat,
                              input logic [39:0] eb, input logic es);
        bit seen;
        seen = 1'b0;
        n    = 0;
        mcnt = 0;
        while (!seen && n < 200) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (bus.mesgul === 1'b1) mcnt++;
            if (bus.cikis_gecerli === 1'b1) seen = 1'b1;
        end
        chk({tag, " latency"}, 64'(n), 64'(exp_lat));
        chk({tag, " basamak"}, 64'(bus.basamak), 64'(eb));
        chk({tag, " isaret"},  64'(bus.isaret),  64'(es));
    endtask

    initial begin
        vec         = 0;
        miss        = 0;
        rst_n       = 1'b0;
        bus.sonuc   = '0;
        bus.hazir   = 1'b0;
        bus.gecerli = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset basamak", 64'(bus.basamak), 64'd0);
        chk("reset isaret",  64'(bus.isaret), 64'd0);
        chk("reset cikis",   64'(bus.cikis_gecerli), 64'd0);
        chk("reset mesgul",  64'(bus.mesgul), 64'd0);
`ifdef SIFIR_BASTIR_EN
        chk("reset bos_mask", 64'(bus.bos_mask), 64'd0);
`endif
        rst_n = 1'b1;

        // 5-3 = 2
        start_conv(64'h0000_0000_0002_0000);
        wait_pulse("plus2", 34, 40'h00_0000_0002, 1'b0);
        chk("plus2 mesgul cycles", 64'(mcnt), 64'd34);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.cikis_gecerli === 1'b1) n++;
        end
        chk("hold no repeat", 64'(n), 64'd0);
        chk("hold mesgul idle", 64'(bus.mesgul), 64'd0);

        // 3-5 = -2
        start_conv(64'h0000_FFFF_FFFE_0000);
        wait_pulse("minus2", 34, 40'h00_0000_0002, 1'b1);

        // max positive, junk in ignored bits
        start_conv(64'hABCD_7FFF_FFFF_1234);
        wait_pulse("max", 34, 40'h21_4748_3647, 1'b0);

        // most negative
        start_conv(64'h0000_8000_0000_0000);
        wait_pulse("min", 34, 40'h21_4748_3648, 1'b1);

        // zero after a negative result
        start_conv(64'h0000_0000_0000_FFFF);
        wait_pulse("zero", 34, 40'h00_0000_0000, 1'b0);
`ifdef SIFIR_BASTIR_EN
        chk("zero bos_mask", 64'(bus.bos_mask), 64'(10'b11_1111_1110));
`endif

        // change input mid-conversion
        start_conv(64'h0000_0000_3039_0000);
        repeat (10) @(negedge clk);
        chk("mid hold basamak", 64'(bus.basamak), 64'd0);
        bus.sonuc = 64'h0000_0000_03E8_0000;
        wait_pulse("mid first", 24, 40'h00_0001_2345, 1'b0);
`ifdef SIFIR_BASTIR_EN
        chk("12345 bos_mask", 64'(bus.bos_mask), 64'(10'b11_1110_0000));
`endif
        wait_pulse("mid second", 35, 40'h00_0000_1000, 1'b0);

        // reset in the middle of a conversion
        start_conv(64'h0000_0000_03E7_0000);
        repeat (15) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async basamak", 64'(bus.basamak), 64'd0);
        chk("async isaret",  64'(bus.isaret), 64'd0);
        chk("async cikis",   64'(bus.cikis_gecerli), 64'd0);
        chk("async mesgul",  64'(bus.mesgul), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_pulse("after reset", 34, 40'h00_0000_0999, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
